// File: rtl/pipe_register_file.sv
// rtl/pipe_register_file.sv - dual-write, multi-read register file with optional bypass and registered reads
module pipe_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter int EDGE_READ  = 0,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clock_in,
    input  logic                           reset,
    input  logic                           regWrite,
    input  logic [ADDR_WIDTH-1:0]          writeReg,
    input  logic [DATA_WIDTH-1:0]          writeData,
    input  logic                           regWrite2,
    input  logic [ADDR_WIDTH-1:0]          writeReg2,
    input  logic [DATA_WIDTH-1:0]          writeData2,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   readReg,
    output logic [NUM_RD*DATA_WIDTH-1:0]   readData
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wrEnA;
    logic                  wrEnB;
    logic [ADDR_WIDTH-1:0] rdAddr [NUM_RD];
    logic [NUM_RD*DATA_WIDTH-1:0] rdNext;

    // Writes aimed at a hardwired-zero register are dropped before they reach storage or bypass.
    assign wrEnA = regWrite  && !((ZERO_REG != 0) && (writeReg  == '0));
    assign wrEnB = regWrite2 && !((ZERO_REG != 0) && (writeReg2 == '0));

    // Port B is applied last so it wins when both ports hit the same address.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else begin
            if (wrEnA) regs[writeReg]  <= writeData;
            if (wrEnB) regs[writeReg2] <= writeData2;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_RD; g++) begin : g_addr
            assign rdAddr[g] = readReg[g*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    always_comb begin
        rdNext = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rdNext[i*DATA_WIDTH +: DATA_WIDTH] = regs[rdAddr[i]];
            // A write in a reset cycle is never committed, so it must not be forwarded either.
            if ((BYPASS != 0) && !reset) begin
                if (wrEnA && (writeReg == rdAddr[i]))
                    rdNext[i*DATA_WIDTH +: DATA_WIDTH] = writeData;
                if (wrEnB && (writeReg2 == rdAddr[i]))
                    rdNext[i*DATA_WIDTH +: DATA_WIDTH] = writeData2;
            end
            if ((ZERO_REG != 0) && (rdAddr[i] == '0))
                rdNext[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
    end

    generate
        if (EDGE_READ != 0) begin : g_edge
            always_ff @(posedge clock_in) begin
                if (reset) readData <= '0;
                else       readData <= rdNext;
            end
        end else begin : g_comb
            assign readData = rdNext;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_register_file.sv
// tb/tb_pipe_register_file.sv - directed self-checking bench across bypass, edge-read and zero-register variants
module tb_pipe_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWrite, regWrite2;
    logic [4:0]  writeReg, writeReg2;
    logic [31:0] writeData, writeData2;
    logic [9:0]  readReg;
    logic [63:0] rdDef, rdNoByp, rdEdge, rdNoZero;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    pipe_register_file dutDef (
        .clock_in(clk), .reset(reset),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .regWrite2(regWrite2), .writeReg2(writeReg2), .writeData2(writeData2),
        .readReg(readReg), .readData(rdDef));

    pipe_register_file #(.BYPASS(0)) dutNoByp (
        .clock_in(clk), .reset(reset),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .regWrite2(regWrite2), .writeReg2(writeReg2), .writeData2(writeData2),
        .readReg(readReg), .readData(rdNoByp));

    pipe_register_file #(.EDGE_READ(1)) dutEdge (
        .clock_in(clk), .reset(reset),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .regWrite2(regWrite2), .writeReg2(writeReg2), .writeData2(writeData2),
        .readReg(readReg), .readData(rdEdge));

    pipe_register_file #(.ZERO_REG(0)) dutNoZero (
        .clock_in(clk), .reset(reset),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .regWrite2(regWrite2), .writeReg2(writeReg2), .writeData2(writeData2),
        .readReg(readReg), .readData(rdNoZero));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regWrite = 1'b0; regWrite2 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        readReg = {5'd31, 5'd0};
        repeat (10) tick();
        reset = 1'b0;
        @(negedge clk);
        nCompared++;
        if (rdDef !== 64'h0) begin
            nMismatched++; $display("FAIL reset_def got %h want %h", rdDef, 64'h0);
        end
        nCompared++;
        if (rdNoByp !== 64'h0) begin
            nMismatched++; $display("FAIL reset_nobyp got %h want %h", rdNoByp, 64'h0);
        end
        nCompared++;
        if (rdEdge !== 64'h0) begin
            nMismatched++; $display("FAIL reset_edge got %h want %h", rdEdge, 64'h0);
        end
        nCompared++;
        if (rdNoZero !== 64'h0) begin
            nMismatched++; $display("FAIL reset_nozero got %h want %h", rdNoZero, 64'h0);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFF_FFFF;
        readReg = {5'd0, 5'd0};
        @(negedge clk);
        nCompared++;
        if (rdDef[31:0] !== 32'h0) begin
            nMismatched++; $display("FAIL zero_bypass got %h want %h", rdDef[31:0], 32'h0);
        end
        nCompared++;
        if (rdNoZero[31:0] !== 32'hFFFF_FFFF) begin
            nMismatched++; $display("FAIL nozero_bypass got %h want %h", rdNoZero[31:0], 32'hFFFF_FFFF);
        end
        tick();
        writeReg = 5'd5;
        tick();
        idle();
        readReg = {5'd5, 5'd0};
        @(negedge clk);
        nCompared++;
        if (rdDef !== {32'hFFFF_FFFF, 32'h0}) begin
            nMismatched++; $display("FAIL zero_reg got %h want %h", rdDef, {32'hFFFF_FFFF, 32'h0});
        end
        nCompared++;
        if (rdNoZero[31:0] !== 32'hFFFF_FFFF) begin
            nMismatched++; $display("FAIL nozero_reg0 got %h want %h", rdNoZero[31:0], 32'hFFFF_FFFF);
        end
        tick();
    endtask

    task automatic test_both_ports();
        regWrite  = 1'b1; writeReg  = 5'd7; writeData  = 32'h1111_1111;
        regWrite2 = 1'b1; writeReg2 = 5'd7; writeData2 = 32'h2222_2222;
        tick();
        writeReg  = 5'd10; writeData  = 32'hAAAA_0001;
        writeReg2 = 5'd11; writeData2 = 32'hBBBB_0002;
        tick();
        idle();
        readReg = {5'd7, 5'd7};
        @(negedge clk);
        nCompared++;
        if (rdDef !== {32'h2222_2222, 32'h2222_2222}) begin
            nMismatched++; $display("FAIL b_wins got %h want %h", rdDef, {32'h2222_2222, 32'h2222_2222});
        end
        readReg = {5'd11, 5'd10};
        @(negedge clk);
        nCompared++;
        if (rdDef !== {32'hBBBB_0002, 32'hAAAA_0001}) begin
            nMismatched++; $display("FAIL dual_write got %h want %h", rdDef, {32'hBBBB_0002, 32'hAAAA_0001});
        end
        tick();
    endtask

    task automatic test_bypass();
        regWrite = 1'b1; writeReg = 5'd3; writeData = 32'hA5A5_A5A5;
        tick();
        writeData = 32'h5A5A_5A5A;
        readReg = {5'd3, 5'd3};
        @(negedge clk);
        nCompared++;
        if (rdDef !== {32'h5A5A_5A5A, 32'h5A5A_5A5A}) begin
            nMismatched++; $display("FAIL bypass_on got %h want %h", rdDef, {32'h5A5A_5A5A, 32'h5A5A_5A5A});
        end
        nCompared++;
        if (rdNoByp[31:0] !== 32'hA5A5_A5A5) begin
            nMismatched++; $display("FAIL bypass_off got %h want %h", rdNoByp[31:0], 32'hA5A5_A5A5);
        end
        tick();
        idle();
        nCompared++;
        if (rdEdge[31:0] !== 32'h5A5A_5A5A) begin
            nMismatched++; $display("FAIL edge_bypass got %h want %h", rdEdge[31:0], 32'h5A5A_5A5A);
        end
        @(negedge clk);
        nCompared++;
        if (rdNoByp[31:0] !== 32'h5A5A_5A5A) begin
            nMismatched++; $display("FAIL nobyp_later got %h want %h", rdNoByp[31:0], 32'h5A5A_5A5A);
        end
        regWrite  = 1'b1; writeData  = 32'h0101_0101;
        regWrite2 = 1'b1; writeReg2 = 5'd3; writeData2 = 32'h0202_0202;
        @(negedge clk);
        nCompared++;
        if (rdDef[63:32] !== 32'h0202_0202) begin
            nMismatched++; $display("FAIL bypass_b_prio got %h want %h", rdDef[63:32], 32'h0202_0202);
        end
        tick();
        idle();
    endtask

    task automatic test_edge_read();
        regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h1234_5678;
        readReg = {5'd0, 5'd0};
        tick();
        idle();
        readReg = {5'd0, 5'd9};
        @(negedge clk);
        nCompared++;
        if (rdEdge[31:0] !== 32'h0) begin
            nMismatched++; $display("FAIL edge_early got %h want %h", rdEdge[31:0], 32'h0);
        end
        nCompared++;
        if (rdDef[31:0] !== 32'h1234_5678) begin
            nMismatched++; $display("FAIL comb_read got %h want %h", rdDef[31:0], 32'h1234_5678);
        end
        tick();
        @(negedge clk);
        nCompared++;
        if (rdEdge[31:0] !== 32'h1234_5678) begin
            nMismatched++; $display("FAIL edge_latency got %h want %h", rdEdge[31:0], 32'h1234_5678);
        end
    endtask

    task automatic test_reset_write();
        regWrite = 1'b1; writeReg = 5'd4; writeData = 32'h0BAD_F00D;
        tick();
        reset = 1'b1; writeData = 32'hDEAD_BEEF;
        readReg = {5'd4, 5'd4};
        @(negedge clk);
        nCompared++;
        if (rdDef[31:0] !== 32'h0BAD_F00D) begin
            nMismatched++; $display("FAIL reset_no_fwd got %h want %h", rdDef[31:0], 32'h0BAD_F00D);
        end
        tick();
        reset = 1'b0;
        idle();
        nCompared++;
        if (rdEdge !== 64'h0) begin
            nMismatched++; $display("FAIL edge_reset_clr got %h want %h", rdEdge, 64'h0);
        end
        @(negedge clk);
        nCompared++;
        if (rdDef[31:0] !== 32'h0) begin
            nMismatched++; $display("FAIL reset_write got %h want %h", rdDef[31:0], 32'h0);
        end
        nCompared++;
        if (rdNoZero[63:32] !== 32'h0) begin
            nMismatched++; $display("FAIL reset_write_nz got %h want %h", rdNoZero[63:32], 32'h0);
        end
        regWrite = 1'b1; writeData = 32'h0000_0077;
        tick();
        idle();
        @(negedge clk);
        nCompared++;
        if (rdNoByp[31:0] !== 32'h0000_0077) begin
            nMismatched++; $display("FAIL first_write got %h want %h", rdNoByp[31:0], 32'h0000_0077);
        end
    endtask

    initial begin
        reset = 1'b1;
        regWrite = 1'b0; regWrite2 = 1'b0;
        writeReg = '0; writeReg2 = '0;
        writeData = '0; writeData2 = '0;
        readReg = '0;
        test_reset();
        test_zero_reg();
        test_both_ports();
        test_bypass();
        test_edge_read();
        test_reset_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/pipe_register_file.md
PIPE_REGISTER_FILE -- requirements
Module: pipe_register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register.
REQ-002 Parameter ADDR_WIDTH, default 5; depth = 2**ADDR_WIDTH registers.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports, range 1..4.
REQ-004 Parameter BYPASS, default 1; 1 = same-cycle write forwarded to reads, 0 = reads return pre-write contents.
REQ-005 Parameter EDGE_READ, default 0; 0 = combinational read, 1 = read data registered on clock_in rising edge.
REQ-006 Parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-007 Port clock_in, input, 1, sole clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1, synchronous, active-high; takes effect only on a clock_in rising edge.
REQ-009 Port regWrite, input, 1, write enable for port A.
REQ-010 Port writeReg, input, ADDR_WIDTH, port A write address.
REQ-011 Port writeData, input, DATA_WIDTH, port A write data.
REQ-012 Port regWrite2, input, 1, write enable for port B.
REQ-013 Port writeReg2, input, ADDR_WIDTH, port B write address.
REQ-014 Port writeData2, input, DATA_WIDTH, port B write data.
REQ-015 Port readReg, input, NUM_RD*ADDR_WIDTH, packed read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-016 Port readData, output, NUM_RD*DATA_WIDTH, packed read data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-017 Write: on rising edge with reset=0 and regWrite=1, register[writeReg] SHALL take writeData; same for port B with regWrite2/writeReg2/writeData2.
REQ-018 Both ports enabled, same address: port B data SHALL be stored (B wins); different addresses: both stored same edge.
REQ-019 ZERO_REG=1: writes to address 0 from either port SHALL be discarded; reads of address 0 SHALL return 0, including through bypass.
REQ-020 ZERO_REG=0: register 0 SHALL behave as an ordinary register.
REQ-021 EDGE_READ=0: readData[i] SHALL combinationally reflect register[readReg[i]], zero latency.
REQ-022 EDGE_READ=1: readData[i] SHALL be registered on the rising edge from the address presented in the preceding cycle; latency exactly 1 cycle.
REQ-023 BYPASS=1: a read whose address matches an enabled write in the same cycle (nonzero address, or any address when ZERO_REG=0) SHALL return that write data, port B taking priority over port A.
REQ-024 BYPASS=1, EDGE_READ=0: forwarding combinational from write inputs; EDGE_READ=1: forwarded value captured into the read register on the same edge as the write.
REQ-025 BYPASS=0: same-cycle read SHALL return the old value (EDGE_READ=0) or the captured old value (EDGE_READ=1); new value visible one cycle later.
REQ-026 Read ports SHALL be fully independent; any ports may address the same register simultaneously.
REQ-027 Addresses SHALL be fully decoded; no out-of-range case exists.

Reset
REQ-028 Edge with reset=1: all registers SHALL clear to 0; writes in that cycle SHALL be ignored, and bypass SHALL NOT forward them.
REQ-029 EDGE_READ=1: read output registers SHALL clear to 0 on reset; EDGE_READ=0: readData follows cleared contents immediately after the reset edge.
REQ-030 Reset asserted mid-sequence SHALL discard pending writes; first write accepted on the first edge with reset=0.
REQ-031 Before the first reset edge, contents are undefined; bench SHALL reset before checking.

Verification
REQ-032 Defaults; reset 10 cycles, read addresses 0 and 31 -> readData = 0 on both ports.
REQ-033 Defaults; write 0xFFFFFFFF to reg 0, then reg 5 -> reg 0 reads 0x00000000, reg 5 reads 0xFFFFFFFF.
REQ-034 Defaults; write A: reg 7=0x11111111 and B: reg 7=0x22222222 same edge -> reg 7 reads 0x22222222.
REQ-035 BYPASS=1 vs 0, EDGE_READ=0; reg 3 holds 0xA5A5A5A5, write 0x5A5A5A5A to reg 3 while reading 3 -> same cycle returns 0x5A5A5A5A vs 0xA5A5A5A5.
REQ-036 EDGE_READ=1; write 0x12345678 to reg 9, next cycle present addr 9 -> readData 0x12345678 one edge later, not before.
REQ-037 Write reg 4=0xDEADBEEF with reset=1 same edge, then reset=0 -> reg 4 reads 0x00000000.
